edge_frame_restore: RTL and testbench

EDGE_FRAME_RESTORE -- requirements
Module: edge_frame_restore

---
 rtl/edge_frame_restore.sv | 96 +++++++++
 tb/tb_edge_frame_restore.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/edge_frame_restore.sv
// edge_frame_restore: re-frames an interior pixel stream into a full IW x IH raster with a filled border; define EDGE_FRAME_RESTORE_BORDER_VAL_EN to fill with BORDER_VAL instead of 0.
module edge_frame_restore #(
  parameter int DATAWID = 8,
  parameter int FIFO_AW = 11,
  parameter logic [DATAWID-1:0] BORDER_VAL = 8'hFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din_valid,
  input  logic [DATAWID-1:0] din,
  input  logic [10:0]        IW,
  input  logic [10:0]        IH,
  input  logic               dout_ready,
  output logic               dout_valid,
  output logic [DATAWID-1:0] dout,
  output logic               sof,
  output logic               eol,
  output logic               eof,
  output logic               overflow
);
`ifdef EDGE_FRAME_RESTORE_BORDER_VAL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif
  localparam logic [DATAWID-1:0] FILL = FILL_EN ? BORDER_VAL : '0;
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state;
  logic [DATAWID-1:0] mem [1<<FIFO_AW];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0] count;
  logic [10:0] w, h, row, col;
  logic full, empty, wr, ld, border, last_col, last, pop;
  always_comb begin
    full = count[FIFO_AW];
    empty = count == '0;
    wr = din_valid && !full;
    ld = state == ACTIVE && (!dout_valid || dout_ready);
    last_col = col == w - 11'd1;
    border = row == '0 || row == h - 11'd1 || col == '0 || last_col;
    last = row == h - 11'd1 && last_col;
    pop = ld && !border && !empty;
  end
  always_ff @(posedge clk)
    if (wr) mem[wr_ptr] <= din;
  // fullness is judged before the same-cycle pop, so a write into a full FIFO is always dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (FIFO_AW+1)'(wr) - (FIFO_AW+1)'(pop);
      if (din_valid && full) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w <= '0;
      h <= '0;
      row <= '0;
      col <= '0;
      dout_valid <= 1'b0;
      dout <= '0;
      sof <= 1'b0;
      eol <= 1'b0;
      eof <= 1'b0;
    end else if (state == IDLE) begin
      if (!dout_valid || dout_ready) dout_valid <= 1'b0;
      if (!empty) begin
        state <= ACTIVE;
        w <= IW;
        h <= IH;
        row <= '0;
        col <= '0;
      end
    end else if (ld) begin
      if (border || !empty) begin
        dout_valid <= 1'b1;
        dout <= border ? FILL : mem[rd_ptr];
        sof <= row == '0 && col == '0;
        eol <= last_col;
        eof <= last;
        col <= last_col ? '0 : col + 11'd1;
        row <= last_col ? row + 11'd1 : row;
        if (last) state <= IDLE;
      end else begin
        dout_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_edge_frame_restore.sv
// tb_edge_frame_restore: directed and randomized checks of edge_frame_restore against a raster/queue reference model.
module tb_edge_frame_restore;
  logic clk = 1'b0, rst = 1'b1, din_valid = 1'b0, dout_ready = 1'b0;
  logic [7:0] din = '0;
  logic [10:0] fw = 11'd5, fh = 11'd5;
  logic dout_valid, sof, eol, eof, overflow;
  logic [7:0] dout;
  logic b_dout_valid, b_sof, b_eol, b_eof, b_overflow;
  logic [7:0] b_dout;
  always #5 clk = ~clk;
  edge_frame_restore dut (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .IW(fw), .IH(fh),
    .dout_ready(dout_ready), .dout_valid(dout_valid), .dout(dout), .sof(sof),
    .eol(eol), .eof(eof), .overflow(overflow));
  edge_frame_restore #(.FIFO_AW(2)) dut_small (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din(din), .IW(fw), .IH(fh),
    .dout_ready(dout_ready), .dout_valid(b_dout_valid), .dout(b_dout), .sof(b_sof),
    .eol(b_eol), .eof(b_eof), .overflow(b_overflow));
`ifdef EDGE_FRAME_RESTORE_BORDER_VAL_EN
  logic [7:0] fill = 8'hFF;
`else
  logic [7:0] fill = 8'h00;
`endif
  int n_chk = 0, n_err = 0;
  logic [7:0] q[$];
  int qs[$];
  logic [7:0] bpix[$];
  bit bcap = 0, held = 0;
  int mr = 0, mc = 0, frames = 0, acc = 0, step = 0;
  logic [7:0] h_dout;
  logic h_sof, h_eol, h_eof;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic reset_model();
    q.delete();
    qs.delete();
    mr = 0;
    mc = 0;
    held = 0;
  endtask

  task automatic check_pixel();
    bit bd;
    logic [7:0] e;
    bd = mr == 0 || mr == int'(fh) - 1 || mc == 0 || mc == int'(fw) - 1;
    e = fill;
    if (!bd) begin
      chk("model_q_nonempty", q.size() != 0, 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("latency", (step - qs.pop_front()) >= 2, 1);
      end
    end
    chk("dout", dout, e);
    chk("sof_eol_eof", {sof, eol, eof},
        {mr == 0 && mc == 0, mc == int'(fw) - 1, mc == int'(fw) - 1 && mr == int'(fh) - 1});
    acc++;
    if (mc == int'(fw) - 1) begin
      mc = 0;
      if (mr == int'(fh) - 1) begin
        mr = 0;
        frames++;
      end else mr++;
    end else mc++;
  endtask

  // one clock: drive inputs at negedge, judge what the next posedge will accept
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy, input bit r = 1'b0);
    @(negedge clk);
    step++;
    rst = r;
    din_valid = v;
    din = d;
    dout_ready = rdy;
    if (held) begin
      chk("hold_dout", dout, h_dout);
      chk("hold_flags", {dout_valid, sof, eol, eof}, {1'b1, h_sof, h_eol, h_eof});
    end
    held = !r && dout_valid && !rdy;
    h_dout = dout;
    h_sof = sof;
    h_eol = eol;
    h_eof = eof;
    if (bcap && b_dout_valid && rdy) bpix.push_back(b_dout);
    if (!r && dout_valid && rdy) check_pixel();
    if (r) reset_model();
    else if (v) begin
      q.push_back(d);
      qs.push_back(step);
    end
  endtask

  task automatic run_until(input int target, input int mode, input int budget);
    int k = 0;
    while (frames < target && k < budget) begin
      cyc(1'b0, 8'h00, mode == 0 ? 1'b1 : mode == 1 ? step[0] : ($urandom % 3 != 0));
      k++;
    end
    chk("frames_done", frames, target);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {dout_valid, dout, sof, eol, eof, overflow, b_overflow}, '0);
  endtask

  initial begin
    int k, n, pushed;
    bit v;
    repeat (3) cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check_zero("reset_state");
    // nominal 5x5
    frames = 0; acc = 0;
    for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), 1'b1);
    run_until(1, 0, 200);
    chk("nominal_count", acc, 25);
    chk("nominal_q_empty", q.size(), 0);
    // backpressure, ready toggling
    frames = 0; acc = 0;
    for (int i = 1; i <= 9; i++) cyc(1'b1, 8'(i), step[0]);
    run_until(1, 1, 400);
    chk("bp_count", acc, 25);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    chk("idle_after_frame", dout_valid, 0);
    // starvation 4x4
    fw = 11'd4; fh = 11'd4; frames = 0; acc = 0;
    cyc(1'b1, 8'hA1, 1'b1);
    repeat (10) cyc(1'b0, 8'h00, 1'b1);
    chk("starve_valid", dout_valid, 0);
    chk("starve_pos", mr * 16 + mc, 18);
    cyc(1'b1, 8'hA2, 1'b1);
    cyc(1'b1, 8'hA3, 1'b1);
    cyc(1'b1, 8'hA4, 1'b1);
    run_until(1, 0, 200);
    chk("starve_count", acc, 16);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    // 3x3 single centre pixel
    fw = 11'd3; fh = 11'd3; frames = 0; acc = 0;
    cyc(1'b1, 8'h42, 1'b1);
    run_until(1, 0, 100);
    chk("small_count", acc, 9);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    // overflow on the depth-4 instance
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    fw = 11'd4; fh = 11'd4; frames = 0; acc = 0; bcap = 1; bpix.delete();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 1'b0);
      if (i == 4) chk("ovf_before_5th", b_overflow, 0);
      if (i == 5) chk("ovf_after_5th", b_overflow, 1);
    end
    run_until(1, 0, 200);
    repeat (4) cyc(1'b0, 8'h00, 1'b1);
    chk("ovf_sticky", b_overflow, 1);
    chk("ovf_big_fifo_clean", overflow, 0);
    chk("ovf_pix_count", bpix.size(), 16);
    if (bpix.size() == 16) begin
      chk("ovf_i0", bpix[5], 8'h10);
      chk("ovf_i1", bpix[6], 8'h11);
      chk("ovf_i2", bpix[9], 8'h12);
      chk("ovf_i3", bpix[10], 8'h13);
      chk("ovf_border", bpix[0], fill);
    end
    bcap = 0;
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check_zero("ovf_cleared_by_rst");
    // reset after 7 accepted pixels of a 5x5 frame
    fw = 11'd5; fh = 11'd5; frames = 0; acc = 0; n = 0; k = 0;
    while (acc < 7 && k < 100) begin
      cyc(n < 9, 8'($urandom), 1'b1);
      n++; k++;
    end
    chk("mid_accepted", acc, 7);
    cyc(1'b0, 8'h00, 1'b1, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    check_zero("mid_reset_outputs");
    frames = 0; acc = 0;
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'($urandom), $urandom % 2 == 0);
    run_until(1, 2, 400);
    chk("post_reset_count", acc, 25);
    repeat (3) cyc(1'b0, 8'h00, 1'b1);
    // random dims, two frames queued back to back, random gaps and ready
    for (int f = 0; f < 6; f++) begin
      fw = 11'(3 + $urandom % 4); fh = 11'(3 + $urandom % 4);
      n = (int'(fw) - 2) * (int'(fh) - 2);
      frames = 0; acc = 0; pushed = 0; k = 0;
      while (pushed < 2 * n && k < 2000) begin
        v = $urandom % 4 != 0;
        cyc(v, 8'($urandom), $urandom % 3 != 0);
        if (v) pushed++;
        k++;
      end
      run_until(2, 2, 3000);
      chk("rand_count", acc, 2 * int'(fw) * int'(fh));
      repeat (4) cyc(1'b0, 8'h00, 1'b1);
      chk("rand_idle", dout_valid, 0);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
